// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bundle: stage instruction/status inputs toward the
// controller and stage enable/flush/status outputs back to the pipeline.
interface hazard_ctrl_if;
    logic [31:0] instr_ID;
    logic [31:0] instr_EX;
    logic        MemRead_EX;
    logic        RegWEn_EX;
    logic        br_taken_EX;
    logic        mem_req_MEM;
    logic        dmem_ready_i;
    logic        md_done_i;
    logic        stall_clr_i;
    logic        md_start_o;
    logic        pc_en;
    logic        IF_ID_en;
    logic        ID_EX_en;
    logic        EX_MEM_en;
    logic        MEM_WB_en;
    logic        IF_ID_flush;
    logic        ID_EX_flush;
    logic        EX_MEM_flush;
    logic        MEM_WB_flush;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt_o;

    modport master (
        output instr_ID, instr_EX, MemRead_EX, RegWEn_EX, br_taken_EX,
               mem_req_MEM, dmem_ready_i, md_done_i, stall_clr_i,
        input  md_start_o, pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
               IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush,
               state_o, stall_cnt_o
    );

    modport slave (
        input  instr_ID, instr_EX, MemRead_EX, RegWEn_EX, br_taken_EX,
               mem_req_MEM, dmem_ready_i, md_done_i, stall_clr_i,
        output md_start_o, pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
               IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush,
               state_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory stall, iterative mul/div wait,
// taken-branch flush and load-use interlock, plus a saturating stall counter.
module hazard_ctrl (
    input  logic      clk_i,
    input  logic      rst_ni,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MD_WAIT = 2'b01,
        RSV2    = 2'b10,
        RSV3    = 2'b11
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] stall_cnt_q;

    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic [6:0] op_id, op_ex;
    logic       rs1_used, rs2_used, md_ex, load_use, mem_stall;

    assign rs1_id = hz.instr_ID[19:15];
    assign rs2_id = hz.instr_ID[24:20];
    assign op_id  = hz.instr_ID[6:0];
    assign rd_ex  = hz.instr_EX[11:7];
    assign op_ex  = hz.instr_EX[6:0];

    logic unused_instr_bits;
    assign unused_instr_bits = ^{hz.instr_ID[31:25], hz.instr_ID[14:7], hz.instr_EX[24:12]};

    assign rs1_used  = !(op_id == OP_LUI || op_id == OP_AUIPC || op_id == OP_JAL);
    assign rs2_used  = (op_id == OP_OP) || (op_id == OP_STORE) || (op_id == OP_BRANCH);
    assign md_ex     = (op_ex == OP_OP) && (hz.instr_EX[31:25] == 7'b0000001);
    assign mem_stall = hz.mem_req_MEM && !hz.dmem_ready_i;
    assign load_use  = hz.MemRead_EX && hz.RegWEn_EX && (rd_ex != 5'd0) &&
                       ((rs1_used && rs1_id == rd_ex) || (rs2_used && rs2_id == rd_ex));

    logic pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c;
    logic if_id_fl_c, id_ex_fl_c, ex_mem_fl_c, mem_wb_fl_c, md_start_c;

    // Only the highest-priority active condition shapes the controls.
    always_comb begin
        pc_en_c     = 1'b1;
        if_id_en_c  = 1'b1;
        id_ex_en_c  = 1'b1;
        ex_mem_en_c = 1'b1;
        mem_wb_en_c = 1'b1;
        if_id_fl_c  = 1'b0;
        id_ex_fl_c  = 1'b0;
        ex_mem_fl_c = 1'b0;
        mem_wb_fl_c = 1'b0;
        md_start_c  = 1'b0;
        state_d     = RUN;
        if (mem_stall) begin
            pc_en_c     = 1'b0;
            if_id_en_c  = 1'b0;
            id_ex_en_c  = 1'b0;
            ex_mem_en_c = 1'b0;
            mem_wb_fl_c = 1'b1;
            state_d     = (state_q == MD_WAIT) ? MD_WAIT : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (md_ex) begin
                        md_start_c  = 1'b1;
                        pc_en_c     = 1'b0;
                        if_id_en_c  = 1'b0;
                        id_ex_en_c  = 1'b0;
                        ex_mem_fl_c = 1'b1;
                        state_d     = MD_WAIT;
                    end else if (hz.br_taken_EX) begin
                        if_id_fl_c = 1'b1;
                        id_ex_fl_c = 1'b1;
                    end else if (load_use) begin
                        pc_en_c    = 1'b0;
                        if_id_en_c = 1'b0;
                        id_ex_fl_c = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (!hz.md_done_i) begin
                        pc_en_c     = 1'b0;
                        if_id_en_c  = 1'b0;
                        id_ex_en_c  = 1'b0;
                        ex_mem_fl_c = 1'b1;
                        state_d     = MD_WAIT;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (hz.stall_clr_i)
                stall_cnt_q <= 16'd0;
            else if (!pc_en_c)
                stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    // Reset masks every control immediately, independent of the clock.
    assign hz.pc_en        = rst_ni & pc_en_c;
    assign hz.IF_ID_en     = rst_ni & if_id_en_c;
    assign hz.ID_EX_en     = rst_ni & id_ex_en_c;
    assign hz.EX_MEM_en    = rst_ni & ex_mem_en_c;
    assign hz.MEM_WB_en    = rst_ni & mem_wb_en_c;
    assign hz.IF_ID_flush  = rst_ni & if_id_fl_c;
    assign hz.ID_EX_flush  = rst_ni & id_ex_fl_c;
    assign hz.EX_MEM_flush = rst_ni & ex_mem_fl_c;
    assign hz.MEM_WB_flush = rst_ni & mem_wb_fl_c;
    assign hz.md_start_o   = rst_ni & md_start_c;
    assign hz.state_o      = state_q;
    assign hz.stall_cnt_o  = stall_cnt_q;
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk_i  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: rst_ni  in  1  reset; asynchronous assert, active-low.
REQ-003 SHALL have ports: instr_ID, instr_EX  in  32 each  instruction words in ID and EX stages.
REQ-004 SHALL have ports: MemRead_EX, RegWEn_EX  in  1 each  load in EX; EX instruction writes rd.
REQ-005 SHALL have ports: br_taken_EX  in  1  branch/jump resolved taken in EX.
REQ-006 SHALL have ports: mem_req_MEM  in  1  MEM stage accesses dmem; dmem_ready_i  in  1  dmem completes this cycle.
REQ-007 SHALL have ports: md_done_i  in  1  iterative mul/div result valid; md_start_o  out  1  one-cycle start pulse.
REQ-008 SHALL have ports: pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en  out  1 each  stage register load enables.
REQ-009 SHALL have ports: IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush  out  1 each  load NOP bubble into the register.
REQ-010 SHALL have ports: state_o  out  2  FSM state; stall_cnt_o  out  16  saturating stall-cycle count; stall_clr_i  in  1  synchronous counter clear.

Function
REQ-011 SHALL implement FSM states RUN=2'b00, MD_WAIT=2'b01; 2'b10/2'b11 unused, return to RUN next cycle.
REQ-012 SHALL decode rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7], opcode=instr[6:0]; rs1 used unless opcode is LUI/AUIPC/JAL; rs2 used only for opcode 0110011, 0100011, 1100011.
REQ-013 SHALL define md_EX = opcode_EX==0110011 and instr_EX[31:25]==0000001.
REQ-014 Default (no condition): all *_en=1, all *_flush=0, md_start_o=0.
REQ-015 Priority, highest first: mem stall, MD, branch flush, load-use; only the highest active condition drives outputs.
REQ-016 Mem stall (mem_req_MEM=1, dmem_ready_i=0, any state): pc_en, IF_ID_en, ID_EX_en, EX_MEM_en =0; MEM_WB_flush=1; state held; md_start_o=0.
REQ-017 RUN with md_EX: md_start_o=1, pc_en, IF_ID_en, ID_EX_en=0, EX_MEM_flush=1; next state MD_WAIT.
REQ-018 MD_WAIT with md_done_i=0: same freeze as REQ-017 but md_start_o=0.
REQ-019 MD_WAIT with md_done_i=1: default outputs (EX_MEM captures result); next state RUN.
REQ-020 md_done_i SHALL be ignored in RUN; md_start_o SHALL never assert in MD_WAIT.
REQ-021 Branch (RUN, br_taken_EX=1, no md_EX): pc_en=1, IF_ID_flush=1, ID_EX_flush=1; overrides load-use.
REQ-022 Load-use (RUN, MemRead_EX=1, RegWEn_EX=1, rd_EX!=0, rd_EX matches a used rs1/rs2 of ID): pc_en=0, IF_ID_en=0, ID_EX_flush=1; lasts exactly one cycle since the load advances.
REQ-023 stall_cnt_o SHALL increment each cycle pc_en=0, saturate at 16'hFFFF, clear on stall_clr_i (clear wins over increment).

Reset
REQ-024 rst_ni=0 SHALL immediately force state RUN, stall_cnt_o=0, md_start_o=0, all *_en=0, all *_flush=0, regardless of clock.
REQ-025 Reset during MD_WAIT SHALL abandon the operation; after release the FSM starts in RUN with no md_start_o until md_EX is seen.
REQ-026 First edge after rst_ni rises SHALL evaluate normal REQ-014..REQ-023 behaviour.

Verification
REQ-027 Load-use: ID=add x3,x1,x2, EX=lw x1 -> one cycle pc_en=0, IF_ID_en=0, ID_EX_flush=1, stall_cnt_o 0->1; rd_EX=x0 -> no stall.
REQ-028 Mul/div: EX=mul, md_done_i at 4th cycle -> md_start_o high cycle 1 only, state_o 01 cycles 2-4, EX_MEM_flush=1 cycles 1-3, EX_MEM_en=1 cycle 4, state RUN cycle 5.
REQ-029 Branch + load-use same cycle: br_taken_EX=1 with hazard -> IF_ID_flush=ID_EX_flush=1, pc_en=1, counter unchanged.
REQ-030 Mem stall in MD_WAIT with md_done_i=1 -> state held MD_WAIT, MEM_WB_flush=1; completes when dmem_ready_i=1 and md_done_i=1.
REQ-031 Counter: hold pc_en=0 for 70000 cycles -> stall_cnt_o=16'hFFFF; stall_clr_i=1 -> 0.
REQ-032 Async reset mid-MD_WAIT between edges -> outputs/state reset before next edge; no md_start_o after release unless md_EX.
